// File: rtl/mcseq_pkg.sv
// Shared types and constants for the multi-cycle CPU sequencer.
// State encoding, opcode map, ALU function codes, immediate formats and
// small opcode-class helpers used by both the FSM and the output decoder.
package mcseq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  // Opcodes 00xx (R-type) and 01xx (ALU-immediate) are recognised by op[3] == 0.
  localparam logic [3:0] OP_LDR  = 4'b1000;
  localparam logic [3:0] OP_STR  = 4'b1001;
  localparam logic [3:0] OP_B    = 4'b1010;
  localparam logic [3:0] OP_BEQ  = 4'b1011;
  localparam logic [3:0] OP_NOP  = 4'b1100;
  localparam logic [3:0] OP_ILL0 = 4'b1101;
  localparam logic [3:0] OP_ILL1 = 4'b1110;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  localparam logic [1:0] IMM_ALU = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;

  // R-type or ALU-immediate
  function automatic logic is_alu_op(input logic [3:0] op);
    return ~op[3];
  endfunction

  // LDR or STR
  function automatic logic is_mem_op(input logic [3:0] op);
    return (op[3:1] == 3'b100);
  endfunction

  // B or BEQ
  function automatic logic is_branch_op(input logic [3:0] op);
    return (op[3:1] == 3'b101);
  endfunction

  function automatic logic is_illegal_op(input logic [3:0] op);
    return (op == OP_ILL0) || (op == OP_ILL1);
  endfunction

  // Opcodes that need an EXEC cycle after DECODE
  function automatic logic needs_exec(input logic [3:0] op);
    return is_alu_op(op) || is_mem_op(op) || is_branch_op(op);
  endfunction

endpackage

// File: rtl/mcseq_out_decode.sv
// Combinational strobe decoder for the multi-cycle sequencer.
// Maps (state, op, op_q, zero, mem_ready) to the datapath control strobes.
// op is the live IR field, used only in DECODE for illegal-opcode detection;
// every other state decodes from the latched op_q.
module mcseq_out_decode
  import mcseq_pkg::*;
(
  input  logic [2:0] state,
  input  logic [3:0] op,
  input  logic [3:0] op_q,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic       reg_write,
  output logic       alu_src,
  output logic [1:0] imm_src,
  output logic       result_src,
  output logic [2:0] alu_control,
  output logic       halted,
  output logic       illegal_op
);

  state_t st;
  assign st = state_t'(state);

  // Per-state strobe decode; everything defaults low so IDLE/HALT stay quiet.
  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    adr_src     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 1'b0;
    reg_write   = 1'b0;
    alu_src     = 1'b0;
    imm_src     = IMM_ALU;
    result_src  = 1'b0;
    alu_control = ALU_ADD;
    halted      = 1'b0;
    illegal_op  = 1'b0;
    case (st)
      S_FETCH: begin
        // Instruction address comes from PC; IR and PC+1 load on the completing cycle.
        mem_req  = 1'b1;
        adr_src  = 1'b0;
        ir_write = mem_ready;
        pc_write = mem_ready;
        pc_src   = 1'b0;
      end
      S_DECODE: begin
        illegal_op = is_illegal_op(op);
      end
      S_EXEC: begin
        if (is_alu_op(op_q)) begin
          alu_control = {1'b0, op_q[1:0]};
          alu_src     = op_q[2];
          imm_src     = IMM_ALU;
        end else if (is_mem_op(op_q)) begin
          alu_control = ALU_ADD;
          alu_src     = 1'b1;
          imm_src     = IMM_MEM;
        end else if (op_q == OP_B) begin
          pc_write = 1'b1;
          pc_src   = 1'b1;
          imm_src  = IMM_BR;
        end else if (op_q == OP_BEQ) begin
          alu_control = ALU_SUB;
          pc_write    = zero;
          pc_src      = 1'b1;
        end
      end
      S_MEM: begin
        // Data address comes from the ALU result register.
        mem_req = 1'b1;
        adr_src = 1'b1;
        mem_we  = (op_q == OP_STR);
      end
      S_WB: begin
        reg_write  = 1'b1;
        result_src = (op_q == OP_LDR);
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle sequencer for the 4-bit-opcode CPU datapath.
// Steps FETCH/DECODE/EXEC/MEM/WB over a single shared memory port.
// Handshake: mem_req is raised by FETCH/MEM and held until a cycle where
// mem_ready is high; that cycle completes the transfer. mem_ready is ignored
// whenever mem_req is low.
// Optional feature macro: MCSEQ_PERF_EN adds cycle_cnt and instr_cnt counters.
module multicycle_sequencer
  import mcseq_pkg::*;
`ifdef MCSEQ_PERF_EN
#(
  parameter int CNT_W = 32
)
`endif
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             reg_write,
  output logic             alu_src,
  output logic [1:0]       imm_src,
  output logic             result_src,
  output logic [2:0]       alu_control,
  output logic             halted,
`ifdef MCSEQ_PERF_EN
  output logic             illegal_op,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
`else
  output logic             illegal_op
`endif
);

  state_t     state;
  logic [3:0] op_q;

  // Sequencer state and latched opcode; op_q is captured only in DECODE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      op_q  <= 4'b0000;
    end else begin
      case (state)
        S_IDLE: state <= S_FETCH;
        S_FETCH: begin
          if (mem_ready) state <= S_DECODE;
        end
        S_DECODE: begin
          op_q <= op;
          if (needs_exec(op))      state <= S_EXEC;
          else if (op == OP_HALT)  state <= S_HALT;
          else                     state <= S_FETCH;  // NOP and illegal opcodes
        end
        S_EXEC: begin
          if (is_alu_op(op_q))      state <= S_WB;
          else if (is_mem_op(op_q)) state <= S_MEM;
          else                      state <= S_FETCH;
        end
        S_MEM: begin
          if (mem_ready) state <= (op_q == OP_STR) ? S_FETCH : S_WB;
        end
        S_WB:    state <= S_FETCH;
        S_HALT:  state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

  mcseq_out_decode u_decode (
    .state       (state),
    .op          (op),
    .op_q        (op_q),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .adr_src     (adr_src),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .reg_write   (reg_write),
    .alu_src     (alu_src),
    .imm_src     (imm_src),
    .result_src  (result_src),
    .alu_control (alu_control),
    .halted      (halted),
    .illegal_op  (illegal_op)
  );

`ifdef MCSEQ_PERF_EN
  logic active;
  logic enter_fetch;

  // An instruction retires on every return to FETCH from a working state.
  always_comb begin
    active      = (state != S_IDLE) && (state != S_HALT);
    enter_fetch = 1'b0;
    case (state)
      S_DECODE: enter_fetch = !needs_exec(op) && (op != OP_HALT);
      S_EXEC:   enter_fetch = is_branch_op(op_q);
      S_MEM:    enter_fetch = mem_ready && (op_q == OP_STR);
      S_WB:     enter_fetch = 1'b1;
      default:  enter_fetch = 1'b0;
    endcase
  end

  // Free-running performance counters, wrapping modulo 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (active)      cycle_cnt <= cycle_cnt + 1'b1;
      if (enter_fetch) instr_cnt <= instr_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer.
// Each stimulus cycle pushes the expected strobe vector into exp_q; a monitor
// on the falling edge pops and compares against the DUT outputs.
module tb_multicycle_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] op = 4'b0000;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, adr_src, ir_write, pc_write, pc_src;
  logic       reg_write, alu_src, result_src, halted, illegal_op;
  logic [1:0] imm_src;
  logic [2:0] alu_control;
`ifdef MCSEQ_PERF_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  // Clock
  always #5 clk = ~clk;

  multicycle_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op          (op),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .adr_src     (adr_src),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .reg_write   (reg_write),
    .alu_src     (alu_src),
    .imm_src     (imm_src),
    .result_src  (result_src),
    .alu_control (alu_control),
    .halted      (halted),
`ifdef MCSEQ_PERF_EN
    .illegal_op  (illegal_op),
    .cycle_cnt   (cycle_cnt),
    .instr_cnt   (instr_cnt)
`else
    .illegal_op  (illegal_op)
`endif
  );

  // Phases of an instruction as seen from outside
  localparam int P_RST  = 0;
  localparam int P_IDLE = 1;
  localparam int P_F    = 2;
  localparam int P_D    = 3;
  localparam int P_E    = 4;
  localparam int P_M    = 5;
  localparam int P_W    = 6;
  localparam int P_H    = 7;

  logic [15:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int exp_cyc = 0;
  int exp_ins = 0;

  wire [15:0] act = {mem_req, mem_we, adr_src, ir_write, pc_write, pc_src, reg_write,
                     alu_src, imm_src, result_src, alu_control, halted, illegal_op};

  // Reference: expected strobes for one cycle of instruction opc in phase ph.
  function automatic logic [15:0] model(int ph, logic [3:0] opc, logic z, logic r);
    logic req, we, adr, irw, pcw, pcs, rw, asrc, rs, hlt, ill;
    logic [1:0] imm;
    logic [2:0] alu;
    req = 0; we = 0; adr = 0; irw = 0; pcw = 0; pcs = 0; rw = 0;
    asrc = 0; rs = 0; hlt = 0; ill = 0; imm = 2'b00; alu = 3'b000;
    case (ph)
      P_F: begin req = 1; irw = r; pcw = r; end
      P_D: ill = (opc == 4'b1101) || (opc == 4'b1110);
      P_E: begin
        if (opc < 4'd8) begin
          alu = {1'b0, opc[1:0]};
          asrc = (opc >= 4'd4);
        end else if (opc == 4'd8 || opc == 4'd9) begin
          asrc = 1; imm = 2'b01;
        end else if (opc == 4'd10) begin
          pcw = 1; pcs = 1; imm = 2'b10;
        end else if (opc == 4'd11) begin
          alu = 3'b001; pcw = z; pcs = 1;
        end
      end
      P_M: begin req = 1; adr = 1; we = (opc == 4'd9); end
      P_W: begin rw = 1; rs = (opc == 4'd8); end
      P_H: hlt = 1;
      default: ;
    endcase
    return {req, we, adr, irw, pcw, pcs, rw, asrc, imm, rs, alu, hlt, ill};
  endfunction

  task automatic check(string nm, logic [31:0] got, logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, got, expv);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [15:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL strobes t=%0t got=%h exp=%h", $time, act, e);
      end
    end
  end

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Driver: one cycle of stimulus, expected vector pushed as it is issued.
  task automatic step(int ph, logic [3:0] opc, logic r, logic z);
    @(posedge clk);
    #1;
    mem_ready = r;
    zero = z;
    op = (ph == P_D) ? opc : 4'($urandom_range(0, 15));
    exp_q.push_back(model(ph, opc, z, r));
    if (ph >= P_F && ph <= P_W) exp_cyc++;
  endtask

  task automatic do_reset(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      mem_ready = rbit();
      exp_q.push_back(16'h0000);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mem_ready = rbit();
    zero = rbit();
    op = 4'($urandom_range(0, 15));
    exp_q.push_back(model(P_IDLE, 4'd0, zero, mem_ready));
    exp_cyc = 0;
    exp_ins = 0;
`ifdef MCSEQ_PERF_EN
    #1;
    check("cycle_cnt_reset", cycle_cnt, 32'd0);
    check("instr_cnt_reset", instr_cnt, 32'd0);
`endif
  endtask

  // zf < 0 randomises the BEQ zero flag; hc is the number of HALT cycles observed.
  task automatic run_instr(logic [3:0] opc, int fw, int mw, int zf, int hc);
    for (int i = 0; i < fw; i++) step(P_F, opc, 1'b0, rbit());
    step(P_F, opc, 1'b1, rbit());
    step(P_D, opc, rbit(), rbit());
    if (opc < 4'd8) begin
      step(P_E, opc, rbit(), rbit());
      step(P_W, opc, rbit(), rbit());
    end else if (opc == 4'd8 || opc == 4'd9) begin
      step(P_E, opc, rbit(), rbit());
      for (int i = 0; i < mw; i++) step(P_M, opc, 1'b0, rbit());
      step(P_M, opc, 1'b1, rbit());
      if (opc == 4'd8) step(P_W, opc, rbit(), rbit());
    end else if (opc == 4'd10 || opc == 4'd11) begin
      step(P_E, opc, rbit(), (zf < 0) ? rbit() : zf[0]);
    end else if (opc == 4'd15) begin
      for (int i = 0; i < hc; i++) step(P_H, opc, rbit(), rbit());
    end
    if (opc != 4'd15) exp_ins++;
  endtask

  // Reset asserted while MEM is waiting on ready: outputs must clear immediately.
  task automatic reset_in_mem();
    step(P_F, 4'd8, 1'b1, rbit());
    step(P_D, 4'd8, rbit(), rbit());
    step(P_E, 4'd8, rbit(), rbit());
    step(P_M, 4'd8, 1'b0, rbit());
    step(P_M, 4'd8, 1'b0, rbit());
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {16'h0, act}, 32'd0);
`ifdef MCSEQ_PERF_EN
    check("cycle_cnt_async", cycle_cnt, 32'd0);
    check("instr_cnt_async", instr_cnt, 32'd0);
`endif
    do_reset(2);
  endtask

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

  // Main sequence
  initial begin
    logic [3:0] ropc;
    do_reset(3);
    run_instr(4'b0000, 0, 0, -1, 0);  // ADD, zero-wait
    run_instr(4'b1000, 2, 2, -1, 0);  // LDR, 2 waits in FETCH and MEM
    run_instr(4'b1001, 0, 0, -1, 0);  // STR
    run_instr(4'b1011, 0, 0, 1, 0);   // BEQ taken
    run_instr(4'b1011, 0, 0, 0, 0);   // BEQ not taken
    run_instr(4'b1010, 1, 0, -1, 0);  // B
    run_instr(4'b1101, 0, 0, -1, 0);  // illegal
    run_instr(4'b1110, 0, 0, -1, 0);  // illegal
    run_instr(4'b1100, 0, 0, -1, 0);  // NOP
    run_instr(4'b0110, 0, 0, -1, 0);  // AND immediate
    run_instr(4'b0011, 1, 0, -1, 0);  // OR
    for (int n = 0; n < 40; n++) begin
      ropc = 4'($urandom_range(0, 14));
      run_instr(ropc, $urandom_range(0, 3), $urandom_range(0, 3), -1, 0);
    end
    reset_in_mem();
    for (int n = 0; n < 5; n++) begin
      ropc = 4'($urandom_range(0, 14));
      run_instr(ropc, $urandom_range(0, 2), $urandom_range(0, 2), -1, 0);
    end
    run_instr(4'b1111, $urandom_range(0, 2), 0, -1, 20);  // HALT
`ifdef MCSEQ_PERF_EN
    #2;
    check("cycle_cnt_halt", cycle_cnt, 32'(exp_cyc));
    check("instr_cnt_halt", instr_cnt, 32'(exp_ins));
`endif
    repeat (2) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
